// File: rtl/riscv_trace_pkg.sv
// rtl/riscv_trace_pkg.sv - shared opcodes, states and record layout for the retire-trace monitor
package riscv_trace_pkg;

  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  localparam int TRACE_XLEN  = 32;
  localparam int TRACE_CNT_W = 32;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTED  = 2'd1,
    TIMEOUT = 2'd2
  } trace_state_t;

  typedef struct packed {
    logic [TRACE_XLEN-1:0]  pc;
    logic [31:0]            instr;
    logic                   rd_we;
    logic [4:0]             rd_addr;
    logic [TRACE_XLEN-1:0]  rd_data;
    logic [TRACE_CNT_W-1:0] cycle;
  } trace_rec_t;

endpackage

// File: rtl/riscv_trace_monitor_fifo.sv
// rtl/riscv_trace_monitor_fifo.sv - first-word-fall-through FIFO with wrap-bit pointers
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the head slot this cycle, so a push into a full FIFO may proceed.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/riscv_trace_monitor.sv
// rtl/riscv_trace_monitor.sv - retire-trace capture, run-control FSM, timeout and drop accounting
module riscv_trace_monitor
  import riscv_trace_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int FIFO_DEPTH     = 16,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int DROP_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              retire_valid,
  input  logic [XLEN-1:0]   retire_pc,
  input  logic [31:0]       retire_instr,
  input  logic              retire_rd_we,
  input  logic [4:0]        retire_rd_addr,
  input  logic [XLEN-1:0]   retire_rd_data,
  input  logic [XLEN-1:0]   a0_value,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [XLEN-1:0]   trace_pc,
  output logic [31:0]       trace_instr,
  output logic              trace_rd_we,
  output logic [4:0]        trace_rd_addr,
  output logic [XLEN-1:0]   trace_rd_data,
  output logic [CNT_W-1:0]  trace_cycle,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              halted,
  output logic              timeout,
  output logic [XLEN-1:0]   result_a0,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);

  localparam int REC_W = XLEN + 32 + 1 + 5 + XLEN + CNT_W;

  trace_state_t state, state_nxt;
  logic             is_system;
  logic             budget_hit;
  logic             push_req;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [REC_W-1:0] rec_in;
  logic [REC_W-1:0] rec_out;

  assign is_system  = retire_valid && (retire_instr[6:0] == OPCODE_SYSTEM);
  assign budget_hit = (TIMEOUT_CYCLES != 0) && (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
  assign push_req   = (state == RUN) && retire_valid;
  assign pop        = trace_valid && trace_ready;
  assign drop       = push_req && fifo_full && !pop;
  assign rec_in     = {retire_pc, retire_instr, retire_rd_we, retire_rd_addr,
                       retire_rd_data, cycle_count};

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (is_system)       state_nxt = HALTED;
        else if (budget_hit) state_nxt = TIMEOUT;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      cycle_count <= '0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      result_a0   <= '0;
      overflow    <= 1'b0;
      drop_count  <= '0;
    end else begin
      state <= state_nxt;
      if (state == RUN) cycle_count <= cycle_count + 1'b1;
      if (state == RUN && state_nxt == HALTED) begin
        halted    <= 1'b1;
        result_a0 <= a0_value;
      end
      if (state == RUN && state_nxt == TIMEOUT) timeout <= 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (!(&drop_count)) drop_count <= drop_count + 1'b1;
      end
    end
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .din   (rec_in),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (rec_out),
    .empty (fifo_empty)
  );

  assign trace_valid = !fifo_empty;

  // Stale RAM contents are hidden so the head fields read as zero whenever nothing is queued.
  always_comb begin
    {trace_pc, trace_instr, trace_rd_we, trace_rd_addr, trace_rd_data, trace_cycle} = '0;
    if (trace_valid) begin
      {trace_pc, trace_instr, trace_rd_we, trace_rd_addr, trace_rd_data, trace_cycle} = rec_out;
    end
  end

endmodule

// File: tb/tb_riscv_trace_monitor.sv
// tb/tb_riscv_trace_monitor.sv - directed self-checking bench for riscv_trace_monitor
module tb_riscv_trace_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_pc = '0;
  logic [31:0] retire_instr = '0;
  logic        retire_rd_we = 1'b0;
  logic [4:0]  retire_rd_addr = '0;
  logic [31:0] retire_rd_data = '0;
  logic [31:0] a0_value = '0;
  logic        trace_ready = 1'b0;
  logic        to_retire_valid = 1'b0;
  logic        to_trace_ready = 1'b0;

  logic        trace_valid, halted, timeout, overflow, trace_rd_we;
  logic [31:0] trace_pc, trace_instr, trace_rd_data, trace_cycle, cycle_count, result_a0;
  logic [4:0]  trace_rd_addr;
  logic [15:0] drop_count;

  logic        to_trace_valid, to_halted, to_timeout, to_overflow, to_trace_rd_we;
  logic [31:0] to_trace_pc, to_trace_instr, to_trace_rd_data, to_trace_cycle, to_cycle_count, to_result_a0;
  logic [4:0]  to_trace_rd_addr;
  logic [15:0] to_drop_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  riscv_trace_monitor #(
    .XLEN(32), .FIFO_DEPTH(16), .CNT_W(32), .TIMEOUT_CYCLES(1000), .DROP_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
    .retire_rd_we(retire_rd_we), .retire_rd_addr(retire_rd_addr), .retire_rd_data(retire_rd_data),
    .a0_value(a0_value),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_rd_we(trace_rd_we),
    .trace_rd_addr(trace_rd_addr), .trace_rd_data(trace_rd_data), .trace_cycle(trace_cycle),
    .cycle_count(cycle_count), .halted(halted), .timeout(timeout), .result_a0(result_a0),
    .overflow(overflow), .drop_count(drop_count)
  );

  riscv_trace_monitor #(
    .XLEN(32), .FIFO_DEPTH(16), .CNT_W(32), .TIMEOUT_CYCLES(10), .DROP_W(16)
  ) dut_to (
    .clk(clk), .reset(reset),
    .retire_valid(to_retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
    .retire_rd_we(retire_rd_we), .retire_rd_addr(retire_rd_addr), .retire_rd_data(retire_rd_data),
    .a0_value(a0_value),
    .trace_valid(to_trace_valid), .trace_ready(to_trace_ready),
    .trace_pc(to_trace_pc), .trace_instr(to_trace_instr), .trace_rd_we(to_trace_rd_we),
    .trace_rd_addr(to_trace_rd_addr), .trace_rd_data(to_trace_rd_data), .trace_cycle(to_trace_cycle),
    .cycle_count(to_cycle_count), .halted(to_halted), .timeout(to_timeout), .result_a0(to_result_a0),
    .overflow(to_overflow), .drop_count(to_drop_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic we, input logic [4:0] rd, input logic [31:0] data);
    retire_valid   = v;
    retire_pc      = pc;
    retire_instr   = instr;
    retire_rd_we   = we;
    retire_rd_addr = rd;
    retire_rd_data = data;
  endtask

  initial begin
    // Reset state
    #1;
    do_reset();
    reset = 1'b0;
    #1;
    chk("rst_valid", trace_valid, 0);
    chk("rst_pc", trace_pc, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_flags", {halted, timeout, overflow}, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_a0", result_a0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Case 1: three retires, consumer stalled
    drive(1, 32'h0, 32'h00500093, 1, 5'd1, 32'd5);
    step();
    chk("c1_valid", trace_valid, 1);
    chk("c1_pc", trace_pc, 32'h0);
    chk("c1_rd", trace_rd_addr, 5'd1);
    chk("c1_cycle", trace_cycle, 0);
    chk("c1_instr", trace_instr, 32'h00500093);
    drive(1, 32'h4, 32'h00A00113, 1, 5'd2, 32'd10);
    step();
    drive(1, 32'h8, 32'h00F00193, 1, 5'd3, 32'd15);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("c1_head_stable", trace_pc, 32'h0);
    chk("c1_cycle_count", cycle_count, 3);

    // Case 2: drain
    trace_ready = 1'b1;
    chk("c2_pc0", trace_pc, 32'h0);
    step();
    chk("c2_pc4", trace_pc, 32'h4);
    chk("c2_rd_data4", trace_rd_data, 32'd10);
    step();
    chk("c2_pc8", trace_pc, 32'h8);
    chk("c2_cycle8", trace_cycle, 2);
    step();
    chk("c2_empty", trace_valid, 0);
    trace_ready = 1'b0;

    // Case 3: overflow with 20 retires into 16 entries
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'(4 * i), 32'h00000013, 0, 5'd0, 32'd0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("c3_overflow", overflow, 1);
    chk("c3_drop", drop_count, 4);
    chk("c3_head", trace_pc, 32'h0);
    trace_ready = 1'b1;
    drive(1, 32'h100, 32'h00000013, 0, 5'd0, 32'd0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("c3_full_pushpop_drop", drop_count, 4);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("c3_drain_pc%0d", i), trace_pc, 64'(4 * i));
      chk($sformatf("c3_drain_cyc%0d", i), trace_cycle, 64'(i));
      step();
    end
    chk("c3_tail_pc", trace_pc, 32'h100);
    step();
    chk("c3_empty", trace_valid, 0);
    trace_ready = 1'b0;

    // Case 4: halt on SYSTEM at cycle 7
    do_reset();
    step(7);
    a0_value = 32'h0000002A;
    drive(1, 32'h1C, 32'h00000073, 0, 5'd0, 32'd0);
    step();
    chk("c4_halted", halted, 1);
    chk("c4_a0", result_a0, 32'h2A);
    chk("c4_cycle", cycle_count, 8);
    chk("c4_timeout", timeout, 0);
    a0_value = 32'h55;
    drive(1, 32'h20, 32'h00000013, 1, 5'd4, 32'd9);
    step(3);
    drive(0, 0, 0, 0, 0, 0);
    chk("c4_cycle_frozen", cycle_count, 8);
    chk("c4_a0_held", result_a0, 32'h2A);
    chk("c4_head_pc", trace_pc, 32'h1C);
    chk("c4_head_cycle", trace_cycle, 7);
    trace_ready = 1'b1;
    step();
    chk("c4_no_late_retire", trace_valid, 0);
    trace_ready = 1'b0;

    // Case 5: timeout after 10 RUN cycles
    do_reset();
    step(9);
    chk("c5_pre_timeout", to_timeout, 0);
    chk("c5_pre_count", to_cycle_count, 9);
    step();
    chk("c5_timeout", to_timeout, 1);
    chk("c5_count", to_cycle_count, 10);
    chk("c5_halted", to_halted, 0);
    step(3);
    chk("c5_count_frozen", to_cycle_count, 10);

    // Halt and timeout in the same cycle: halt wins
    do_reset();
    step(9);
    a0_value = 32'h77;
    retire_instr = 32'h00000073;
    to_retire_valid = 1'b1;
    step();
    to_retire_valid = 1'b0;
    retire_instr = 32'h0;
    chk("c5_tie_halted", to_halted, 1);
    chk("c5_tie_timeout", to_timeout, 0);
    chk("c5_tie_a0", to_result_a0, 32'h77);
    chk("c5_tie_count", to_cycle_count, 10);

    // Case 6: asynchronous reset mid-drain
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, 32'(4 * i), 32'h00000013, 0, 5'd0, 32'd0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("c6_pre_overflow", overflow, 1);
    trace_ready = 1'b1;
    step(11);
    chk("c6_mid_pc", trace_pc, 32'd44);
    #2;
    reset = 1'b0;
    #1;
    chk("c6_valid", trace_valid, 0);
    chk("c6_pc", trace_pc, 0);
    chk("c6_overflow", overflow, 0);
    chk("c6_drop", drop_count, 0);
    chk("c6_cycle", cycle_count, 0);
    chk("c6_to_timeout", to_timeout, 0);
    trace_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
